divider: RTL and testbench
==========================

Name: divider

Overview:
- Multi-cycle 16-bit integer divider; the inverse of the combinational 16x16 multiplier in the arithmetic library.
- Serves the execute stage for DIV/DIVU: quotient goes to LO, remainder goes to HI.
- Restoring shift-subtract algorithm, one quotient bit per cycle.
- Start/busy/done handshake with fixed latency, so the pipeline stall logic can count cycles.

Parameters:
- WIDTH, 16, operand/result width; all text below assumes 16.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  input  16  numerator; sampled with start
- divisor  input  16  denominator; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  16  LO result
- remainder  output  16  HI result
- div_by_zero  output  1  registered flag, updated together with done

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state = IDLE.
  - busy, done, div_by_zero = 0.
  - quotient, remainder = 0.
  - Any in-flight operation is abandoned and no done is issued.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On an edge with start = 1, latch signed_op, the original dividend, the zero-divisor flag, the sign of the quotient (dividend[15] ^ divisor[15], signed ops only) and the sign of the remainder (dividend[15], signed ops only).
  - Latch operand magnitudes: absolute values if signed_op, raw values otherwise.
  - Clear the 17-bit partial remainder; count = 0; busy = 1; go to CALC.
- CALC: 16 cycles. Each edge does one restoring step on the {partial remainder, quotient shift} pair:
  - shift left 1, bringing in the next dividend bit (MSB first);
  - trial = partial - divisor magnitude;
  - if trial is non-negative, keep trial and shift in quotient bit 1; otherwise restore and shift in 0.
  - count increments each step; after the step with count = 15, go to FIX.
- FIX: one edge.
  - Registers quotient, remainder and div_by_zero; done = 1 for exactly one cycle; busy = 0; return to IDLE.
  - Signed result: negate quotient if the quotient sign is set; negate remainder if the remainder sign is set. The remainder therefore takes the sign of the dividend.
- Latency:
  - start sampled at edge N; done and results visible after edge N+17, i.e. 18 cycles of busy/FIX in total.
  - Fixed for every operand pair, including divide by zero.
- Result registers hold their value until the next FIX or reset.
- Divide by zero (divisor = 0, either mode): quotient = 16'hFFFF, remainder = original dividend, div_by_zero = 1. Full latency still applies.
- Signed overflow (-32768 / -1): quotient = 16'h8000, remainder = 0, div_by_zero = 0.
  - Falls out of the algorithm: |0x8000| is treated as the unsigned value 32768.
- start while busy: ignored; the latched operands are unaffected.
- start in the cycle done is high: accepted, because the FSM is already in IDLE; back-to-back operations are legal.
- Operands may change freely after the start edge.

Decomposition:
- Shared package arith_pkg:
  - DIV_WIDTH = 16;
  - state encoding (S_IDLE, S_CALC, S_FIX; 2 bits);
  - DIV_STEPS = 16 and the count width of 5 bits.
  - The multiplier width constant also moves here.
- One natural sub-module: divider_step.
  - Combinational single restoring iteration.
  - Inputs: 17-bit partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next partial remainder and quotient bit.
- Top level holds the FSM, the counter, the sign/abs logic and the output registers.

Test Plan:
- Unsigned 100 / 7 (signed_op = 0) -> done 18 cycles after start; quotient = 14, remainder = 2; busy high for 17 cycles before done.
- Signed -7 (16'hFFF9) / 2 -> quotient = 16'hFFFD (-3), remainder = 16'hFFFF (-1). Signed 7 / -2 -> quotient = 16'hFFFD, remainder = 1.
- Boundaries:
  - unsigned 16'hFFFF / 1 -> quotient = 16'hFFFF, remainder = 0;
  - signed 16'h8000 / 16'hFFFF -> quotient = 16'h8000, remainder = 0;
  - unsigned 5 / 16'hFFFF -> quotient = 0, remainder = 5.
- Divide by zero: 16'h04D2 / 0 in both modes -> quotient = 16'hFFFF, remainder = 16'h04D2, div_by_zero = 1, same 18-cycle latency.
  - The next valid divide clears div_by_zero.
- Handshake:
  - start pulsed again mid-CALC with different operands -> ignored, first result unchanged;
  - start asserted in the done cycle -> second result after exactly 18 more cycles.
- Reset asserted at CALC cycle 8 -> next cycle busy = 0, quotient = remainder = 0, and done is never pulsed for the abandoned operation.

Source files
------------

// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared constants and types for the arithmetic library
//               (16x16 multiplier and multi-cycle divider).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int MUL_WIDTH  = 16;
    localparam int DIV_WIDTH  = 16;
    localparam int DIV_STEPS  = 16;
    localparam int CNT_WIDTH  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/divider_step.sv
// ============================================================================
// Module      : divider_step
// Description : One combinational restoring shift-subtract iteration.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module divider_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   partial,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_partial,
    output logic             quotient_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // partial < divisor always holds, so the shifted value never exceeds
    // WIDTH+1 bits; one extra bit on the trial carries the borrow.
    assign shifted      = {partial[WIDTH-1:0], dividend_bit};
    assign trial        = {1'b0, shifted} - {2'b00, divisor};
    assign quotient_bit = ~trial[WIDTH+1];
    assign next_partial = quotient_bit ? trial[WIDTH:0] : shifted;

endmodule

`default_nettype wire

// File: rtl/divider.sv
// ============================================================================
// Module      : divider
// Description : Fixed-latency restoring divider for DIV/DIVU (LO=quotient,
//               HI=remainder), start/busy/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t           state;
    logic [CNT_WIDTH-1:0] count;
    logic [WIDTH-1:0]     orig_dividend;
    logic                 zero_div;
    logic                 quot_neg;
    logic                 rem_neg;
    logic [WIDTH-1:0]     divisor_mag;
    logic [WIDTH-1:0]     quot_shift;
    logic [WIDTH:0]       partial;

    logic [WIDTH:0]       next_partial;
    logic                 quotient_bit;
    logic [WIDTH-1:0]     dividend_abs;
    logic [WIDTH-1:0]     divisor_abs;

    // The most negative value has no positive counterpart in WIDTH bits; its
    // negation wraps back to itself and is then read as an unsigned magnitude.
    assign dividend_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .partial      (partial),
        .dividend_bit (quot_shift[WIDTH-1]),
        .divisor      (divisor_mag),
        .next_partial (next_partial),
        .quotient_bit (quotient_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            orig_dividend <= '0;
            zero_div      <= 1'b0;
            quot_neg      <= 1'b0;
            rem_neg       <= 1'b0;
            divisor_mag   <= '0;
            quot_shift    <= '0;
            partial       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        orig_dividend <= dividend;
                        zero_div      <= (divisor == '0);
                        quot_neg      <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rem_neg       <= signed_op & dividend[WIDTH-1];
                        quot_shift    <= dividend_abs;
                        divisor_mag   <= divisor_abs;
                        partial       <= '0;
                        count         <= '0;
                        busy          <= 1'b1;
                        state         <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Dividend bits leave at the top while quotient bits
                    // enter at the bottom of the same register.
                    partial    <= next_partial;
                    quot_shift <= {quot_shift[WIDTH-2:0], quotient_bit};
                    count      <= count + 1'b1;
                    if (count == CNT_WIDTH'(DIV_STEPS - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (zero_div) begin
                        quotient  <= '1;
                        remainder <= orig_dividend;
                    end else begin
                        quotient  <= quot_neg ? -quot_shift : quot_shift;
                        remainder <= rem_neg ? -partial[WIDTH-1:0] : partial[WIDTH-1:0];
                    end
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module      : tb_divider
// Description : Directed self-checking bench for the divider.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the first negedge after it.
    task automatic start_op(input logic sop, input logic [15:0] a, input logic [15:0] b);
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividend  = 16'hDEAD;
        divisor   = 16'h0BAD;
    endtask

    // Counts negedges since the start negedge until done is seen (bounded).
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic sop, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] eq,
                             input logic [15:0] er, input logic edz);
        int lat, bc;
        start_op(sop, a, b);
        wait_done(1, lat, bc);
        check({tag, " latency"}, lat, 18);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, edz);
    endtask

    initial begin
        int lat, bc;
        bit done_seen;

        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // 100 / 7 unsigned: full handshake timing
        start_op(1'b0, 16'd100, 16'd7);
        wait_done(1, lat, bc);
        check("u100/7 latency", lat, 18);
        check("u100/7 busy cycles", bc, 17);
        check("u100/7 busy in done cycle", busy, 0);
        check("u100/7 quotient", quotient, 16'd14);
        check("u100/7 remainder", remainder, 16'd2);
        check("u100/7 div_by_zero", div_by_zero, 0);
        @(negedge clk);
        check("u100/7 done one cycle", done, 0);
        check("u100/7 quotient held", quotient, 16'd14);

        run_check("s-7/2",      1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0);
        run_check("s7/-2",      1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0);
        run_check("uFFFF/1",    1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0);
        run_check("s8000/FFFF", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0);
        run_check("u5/FFFF",    1'b0, 16'd5,    16'hFFFF, 16'd0,    16'd5,    1'b0);
        run_check("s-100/7",    1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0);
        run_check("udz",        1'b0, 16'h04D2, 16'd0,    16'hFFFF, 16'h04D2, 1'b1);
        run_check("sdz",        1'b1, 16'h04D2, 16'd0,    16'hFFFF, 16'h04D2, 1'b1);
        run_check("sdz neg",    1'b1, 16'hFB2E, 16'd0,    16'hFFFF, 16'hFB2E, 1'b1);
        run_check("dz cleared", 1'b0, 16'd1000, 16'd3,    16'd333,  16'd1,    1'b0);

        // start pulsed mid-CALC with other operands must be ignored
        start_op(1'b0, 16'd1000, 16'd10);
        repeat (4) @(negedge clk);
        start_op(1'b1, 16'd9, 16'd3);
        wait_done(6, lat, bc);
        check("ignore-start latency", lat, 18);
        check("ignore-start quotient", quotient, 16'd100);
        check("ignore-start remainder", remainder, 16'd0);

        // back-to-back: start asserted in the done cycle
        start_op(1'b0, 16'd50000, 16'd7);
        wait_done(1, lat, bc);
        check("b2b first quotient", quotient, 16'd7142);
        check("b2b first remainder", remainder, 16'd6);
        start_op(1'b1, 16'hFC18, 16'hFFF6);
        wait_done(1, lat, bc);
        check("b2b second latency", lat, 18);
        check("b2b second quotient", quotient, 16'd100);
        check("b2b second remainder", remainder, 16'd0);

        // reset during CALC abandons the operation
        start_op(1'b0, 16'd1234, 16'd5);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        done_seen = 1'b0;
        repeat (25) begin
            if (done) done_seen = 1'b1;
            @(negedge clk);
        end
        check("abort no done", done_seen, 0);

        run_check("after abort", 1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
